ultrasonic_pwm_gen: RTL

- Transmit-side counterpart of the ultrasonic pulse-width receiver. Encodes a width value as a single high pulse per frame on a PWM line, in the same format the MaxSonar-style sensor drives.
- Used to emulate the sensor for closed-loop bring-up of the robot's distance/stop path, and as a generic pulse-width transmitter.
- A new width is loaded through a valid/ready handshake. Pulses repeat at a fixed frame period while enabled.

---
 rtl/ultrasonic_pwm_gen.sv | 113 +++++++++++
 1 files changed

// File: rtl/ultrasonic_pwm_gen.sv
// Pulse-width transmitter: one high pulse per fixed-length frame,
// width loaded through a single-entry valid/ready buffer.
module ultrasonic_pwm_gen #(
    parameter int WIDTH_W       = 25,
    parameter int PERIOD_CYCLES = 5000000,
    parameter int MIN_WIDTH     = 14700,
    parameter int MAX_WIDTH     = 3750000
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               enable,
    input  logic [WIDTH_W-1:0] width_in,
    input  logic               width_valid,
    output logic               width_ready,
    output logic               pwm_out,
    output logic               busy,
    output logic               period_done
);

    localparam int PER_W = $clog2(PERIOD_CYCLES + 1);
    localparam int CNT_W = (PER_W > WIDTH_W + 1) ? PER_W : WIDTH_W + 1;

    localparam logic [CNT_W-1:0]   PERIOD_C = CNT_W'(PERIOD_CYCLES);
    localparam logic [WIDTH_W-1:0] MIN_C    = WIDTH_W'(MIN_WIDTH);
    localparam logic [WIDTH_W-1:0] MAX_C    = WIDTH_W'(MAX_WIDTH);

    // Bit 0 is the PULSE flag so pwm_out comes straight from a flop.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PULSE = 2'b01,
        GAP   = 2'b10
    } state_t;

    state_t state;
    state_t state_next;

    logic [CNT_W-1:0]   cnt;
    logic [WIDTH_W-1:0] pending;
    logic [WIDTH_W-1:0] active;
    logic               pending_full;
    logic               xfer;
    logic               pulse_last;
    logic               frame_last;
    logic               frame_start;

    function automatic logic [WIDTH_W-1:0] clamp(input logic [WIDTH_W-1:0] v);
        logic [WIDTH_W-1:0] r;
        r = v;
        if (v < MIN_C) r = MIN_C;
        else if (v > MAX_C) r = MAX_C;
        return r;
    endfunction

    assign xfer        = width_valid && !pending_full;
    assign pulse_last  = (state == PULSE) && (cnt == CNT_W'(active));
    assign frame_last  = (state == GAP) && (cnt == PERIOD_C);
    assign frame_start = enable && ((state == IDLE) || frame_last);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (enable) state_next = PULSE;
            PULSE:   if (pulse_last) state_next = GAP;
            GAP:     if (frame_last) state_next = enable ? PULSE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pwm_out     = state[0];
        busy        = |state;
        period_done = frame_last;
        width_ready = !pending_full;
    end

    // Frame counter: 1 on the first pulse cycle, PERIOD_CYCLES on the last.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cnt          <= '0;
            pending      <= '0;
            pending_full <= 1'b0;
            active       <= MIN_C;
        end else begin
            if (frame_start) begin
                cnt <= CNT_W'(1);
            end else if (frame_last) begin
                cnt <= '0;
            end else if (state != IDLE) begin
                cnt <= cnt + CNT_W'(1);
            end

            if (frame_start && pending_full) begin
                active <= clamp(pending);
            end

            if (xfer) begin
                pending      <= width_in;
                pending_full <= 1'b1;
            end else if (frame_start) begin
                pending_full <= 1'b0;
            end
        end
    end

endmodule
